// File: rtl/pifo_calendar_sorted_if.sv
// Purpose : bundles the insert / pop / drop / status signals of the sorted
//           PIFO calendar so the enqueue agent, egress scheduler and buffer
//           manager side can be wired as one port.
// Modports: slave  - the calendar itself (takes insert/pop, drives results)
//           master - the surrounding agent (drives insert/pop, reads results)
interface pifo_calendar_sorted_if #(
  parameter int RANK_WIDTH        = 32,
  parameter int BUFFER_ADDR_WIDTH = 12,
  parameter int COUNT_WIDTH       = 5
);
  logic                         s_axis_insert_valid;
  logic                         s_axis_insert_ready;
  logic [RANK_WIDTH-1:0]        s_axis_insert_rank;
  logic [BUFFER_ADDR_WIDTH-1:0] s_axis_insert_addr;
  logic                         s_axis_pop_en;
  logic                         m_axis_pop_valid;
  logic [RANK_WIDTH-1:0]        m_axis_pop_rank;
  logic [BUFFER_ADDR_WIDTH-1:0] m_axis_buffer_addr;
  logic                         m_axis_top_valid;
  logic [RANK_WIDTH-1:0]        m_axis_top_rank;
  logic                         m_axis_drop_valid;
  logic [BUFFER_ADDR_WIDTH-1:0] m_axis_drop_addr;
  logic                         m_axis_calendar_full;
  logic                         m_axis_calendar_empty;
  logic [COUNT_WIDTH-1:0]       m_axis_calendar_count;

  modport slave (
    input  s_axis_insert_valid, s_axis_insert_rank, s_axis_insert_addr, s_axis_pop_en,
    output s_axis_insert_ready, m_axis_pop_valid, m_axis_pop_rank, m_axis_buffer_addr,
           m_axis_top_valid, m_axis_top_rank, m_axis_drop_valid, m_axis_drop_addr,
           m_axis_calendar_full, m_axis_calendar_empty, m_axis_calendar_count
  );

  modport master (
    output s_axis_insert_valid, s_axis_insert_rank, s_axis_insert_addr, s_axis_pop_en,
    input  s_axis_insert_ready, m_axis_pop_valid, m_axis_pop_rank, m_axis_buffer_addr,
           m_axis_top_valid, m_axis_top_rank, m_axis_drop_valid, m_axis_drop_addr,
           m_axis_calendar_full, m_axis_calendar_empty, m_axis_calendar_count
  );
endinterface

// File: rtl/pifo_calendar_sorted.sv
// Purpose : sorted PIFO calendar. Keeps up to PIFO_CALENDAR_SIZE {rank, addr}
//           entries in ascending rank order (head = e[0]), FIFO among ties.
//           Supports insert, pop and insert+pop per cycle; when full either
//           backpressures (DROP_MODE 0) or evicts/rejects the worst entry
//           (DROP_MODE 1) and reports the freed address.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous reset, active high
//           bus  - pifo_calendar_sorted_if.slave (insert, pop, drop, status)
module pifo_calendar_sorted #(
  parameter int PIFO_CALENDAR_SIZE = 16,
  parameter int RANK_WIDTH         = 32,
  parameter int BUFFER_ADDR_WIDTH  = 12,
  parameter int DROP_MODE          = 0,
  parameter int COUNT_WIDTH        = $clog2(PIFO_CALENDAR_SIZE + 1)
) (
  input logic clk,
  input logic rst,
  pifo_calendar_sorted_if.slave bus
);
  localparam int SIZE = PIFO_CALENDAR_SIZE;

  logic [RANK_WIDTH-1:0]        rank_q [SIZE];
  logic [RANK_WIDTH-1:0]        rank_d [SIZE];
  logic [BUFFER_ADDR_WIDTH-1:0] addr_q [SIZE];
  logic [BUFFER_ADDR_WIDTH-1:0] addr_d [SIZE];
  logic [SIZE-1:0]              valid_q, valid_d;
  logic [COUNT_WIDTH-1:0]       count_q, count_d;
  logic                         pop_valid_q, pop_valid_d;
  logic [RANK_WIDTH-1:0]        pop_rank_q, pop_rank_d;
  logic [BUFFER_ADDR_WIDTH-1:0] pop_addr_q, pop_addr_d;
  logic                         drop_valid_q, drop_valid_d;
  logic [BUFFER_ADDR_WIDTH-1:0] drop_addr_q, drop_addr_d;

  // Array shifted one slot toward the head (up_*) and toward the tail (dn_*).
  logic [RANK_WIDTH-1:0]        up_rank [SIZE];
  logic [BUFFER_ADDR_WIDTH-1:0] up_addr [SIZE];
  logic [RANK_WIDTH-1:0]        dn_rank [SIZE];
  logic [BUFFER_ADDR_WIDTH-1:0] dn_addr [SIZE];

  for (genvar g = 0; g < SIZE; g++) begin : g_shift
    if (g < SIZE - 1) begin : g_up
      assign up_rank[g] = rank_q[g+1];
      assign up_addr[g] = addr_q[g+1];
    end else begin : g_up_last
      assign up_rank[g] = '0;
      assign up_addr[g] = '0;
    end
    if (g > 0) begin : g_dn
      assign dn_rank[g] = rank_q[g-1];
      assign dn_addr[g] = addr_q[g-1];
    end else begin : g_dn_first
      assign dn_rank[g] = '0;
      assign dn_addr[g] = '0;
    end
  end

  logic full, empty, do_pop, ready, ins, evict;
  int   p, q, cnt;

  assign full   = (count_q == COUNT_WIDTH'(SIZE));
  assign empty  = (count_q == '0);
  assign do_pop = bus.s_axis_pop_en && !empty;
  assign ready  = !rst && ((DROP_MODE != 0) || !full || do_pop);
  assign ins    = bus.s_axis_insert_valid && ready;
  // Strict compare: a tie with the tail is rejected so earlier arrivals win.
  assign evict  = bus.s_axis_insert_rank < rank_q[SIZE-1];
  assign cnt    = int'(count_q);

  // Count of valid entries with rank <= new rank places ties behind equals.
  always_comb begin
    p = 0;
    for (int i = 0; i < SIZE; i++)
      if (valid_q[i] && (rank_q[i] <= bus.s_axis_insert_rank)) p = p + 1;
    q = (p > 0) ? p - 1 : 0;
  end

  always_comb begin
    rank_d       = rank_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    count_d      = count_q;
    pop_valid_d  = do_pop;
    pop_rank_d   = pop_rank_q;
    pop_addr_d   = pop_addr_q;
    drop_valid_d = 1'b0;
    drop_addr_d  = drop_addr_q;
    if (do_pop) begin
      pop_rank_d = rank_q[0];
      pop_addr_d = addr_q[0];
    end
    if (ins && do_pop) begin
      // Head leaves, new entry lands at p-1 of the up-shifted array.
      for (int i = 0; i < SIZE; i++) begin
        if (i < q) begin
          rank_d[i] = up_rank[i];
          addr_d[i] = up_addr[i];
        end else if (i == q) begin
          rank_d[i] = bus.s_axis_insert_rank;
          addr_d[i] = bus.s_axis_insert_addr;
        end
      end
    end else if (ins && (!full || evict)) begin
      for (int i = 0; i < SIZE; i++) begin
        if (i == p) begin
          rank_d[i] = bus.s_axis_insert_rank;
          addr_d[i] = bus.s_axis_insert_addr;
        end else if (i > p) begin
          rank_d[i] = dn_rank[i];
          addr_d[i] = dn_addr[i];
        end
      end
      if (full) begin
        // Tail falls off the end of the down-shift.
        drop_valid_d = 1'b1;
        drop_addr_d  = addr_q[SIZE-1];
      end else begin
        for (int i = 0; i < SIZE; i++) valid_d[i] = (i <= cnt);
        count_d = count_q + COUNT_WIDTH'(1);
      end
    end else if (ins) begin
      drop_valid_d = 1'b1;
      drop_addr_d  = bus.s_axis_insert_addr;
    end else if (do_pop) begin
      for (int i = 0; i < SIZE; i++) begin
        rank_d[i]  = up_rank[i];
        addr_d[i]  = up_addr[i];
        valid_d[i] = (i < cnt - 1);
      end
      count_d = count_q - COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SIZE; i++) begin
        rank_q[i] <= '0;
        addr_q[i] <= '0;
      end
      valid_q      <= '0;
      count_q      <= '0;
      pop_valid_q  <= 1'b0;
      pop_rank_q   <= '0;
      pop_addr_q   <= '0;
      drop_valid_q <= 1'b0;
      drop_addr_q  <= '0;
    end else begin
      rank_q       <= rank_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      count_q      <= count_d;
      pop_valid_q  <= pop_valid_d;
      pop_rank_q   <= pop_rank_d;
      pop_addr_q   <= pop_addr_d;
      drop_valid_q <= drop_valid_d;
      drop_addr_q  <= drop_addr_d;
    end
  end

  assign bus.s_axis_insert_ready   = ready;
  assign bus.m_axis_pop_valid      = pop_valid_q;
  assign bus.m_axis_pop_rank       = pop_rank_q;
  assign bus.m_axis_buffer_addr    = pop_addr_q;
  assign bus.m_axis_top_valid      = valid_q[0];
  assign bus.m_axis_top_rank       = valid_q[0] ? rank_q[0] : '0;
  assign bus.m_axis_drop_valid     = drop_valid_q;
  assign bus.m_axis_drop_addr      = drop_addr_q;
  assign bus.m_axis_calendar_full  = full;
  assign bus.m_axis_calendar_empty = empty;
  assign bus.m_axis_calendar_count = count_q;
endmodule

// File: tb/tb_pifo_calendar_sorted.sv
module tb_pifo_calendar_sorted;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_bad;

  pifo_calendar_sorted_if #(.RANK_WIDTH(32), .BUFFER_ADDR_WIDTH(12), .COUNT_WIDTH(3)) if0 ();
  pifo_calendar_sorted_if #(.RANK_WIDTH(32), .BUFFER_ADDR_WIDTH(12), .COUNT_WIDTH(3)) if1 ();

  pifo_calendar_sorted #(.PIFO_CALENDAR_SIZE(4), .RANK_WIDTH(32), .BUFFER_ADDR_WIDTH(12),
                         .DROP_MODE(0), .COUNT_WIDTH(3))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  pifo_calendar_sorted #(.PIFO_CALENDAR_SIZE(4), .RANK_WIDTH(32), .BUFFER_ADDR_WIDTH(12),
                         .DROP_MODE(1), .COUNT_WIDTH(3))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // One clock with the given request on dut m; outputs are sampled 1ns after the edge.
  task automatic cyc(input bit m, input bit ins, input logic [31:0] rank,
                     input logic [11:0] addr, input bit pop);
    if (m) begin
      if1.s_axis_insert_valid = ins; if1.s_axis_insert_rank = rank;
      if1.s_axis_insert_addr = addr; if1.s_axis_pop_en = pop;
    end else begin
      if0.s_axis_insert_valid = ins; if0.s_axis_insert_rank = rank;
      if0.s_axis_insert_addr = addr; if0.s_axis_pop_en = pop;
    end
    @(posedge clk);
    #1;
    if1.s_axis_insert_valid = 1'b0; if1.s_axis_pop_en = 1'b0;
    if0.s_axis_insert_valid = 1'b0; if0.s_axis_pop_en = 1'b0;
  endtask

  task automatic pop0(input string tag, input logic [11:0] addr);
    cyc(0, 0, 0, 0, 1);
    chk({tag, "_pv"}, if0.m_axis_pop_valid, 1);
    chk({tag, "_pa"}, if0.m_axis_buffer_addr, addr);
  endtask

  task automatic pop1(input string tag, input logic [31:0] rank, input logic [11:0] addr);
    cyc(1, 0, 0, 0, 1);
    chk({tag, "_pv"}, if1.m_axis_pop_valid, 1);
    chk({tag, "_pr"}, if1.m_axis_pop_rank, rank);
    chk({tag, "_pa"}, if1.m_axis_buffer_addr, addr);
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    rst = 1'b1;
    if0.s_axis_insert_valid = 0; if0.s_axis_insert_rank = 0;
    if0.s_axis_insert_addr = 0; if0.s_axis_pop_en = 0;
    if1.s_axis_insert_valid = 0; if1.s_axis_insert_rank = 0;
    if1.s_axis_insert_addr = 0; if1.s_axis_pop_en = 0;
    #12;
    chk("rst_empty", if0.m_axis_calendar_empty, 1);
    chk("rst_full", if0.m_axis_calendar_full, 0);
    chk("rst_count", if0.m_axis_calendar_count, 0);
    chk("rst_ready", if0.s_axis_insert_ready, 0);
    chk("rst_top_valid", if0.m_axis_top_valid, 0);
    chk("rst_pop_valid", if0.m_axis_pop_valid, 0);
    chk("rst_drop_valid1", if1.m_axis_drop_valid, 0);
    #3 rst = 1'b0;
    #1;
    chk("ready_after_rst", if0.s_axis_insert_ready, 1);

    // 1: sorted insert and ordered pops
    cyc(0, 1, 30, 1, 0);
    chk("t1_top_first", if0.m_axis_top_rank, 30);
    cyc(0, 1, 10, 2, 0);
    cyc(0, 1, 20, 3, 0);
    chk("t1_count", if0.m_axis_calendar_count, 3);
    chk("t1_top", if0.m_axis_top_rank, 10);
    pop0("t1_pop0", 2);
    chk("t1_count2", if0.m_axis_calendar_count, 2);
    pop0("t1_pop1", 3);
    pop0("t1_pop2", 1);
    chk("t1_empty", if0.m_axis_calendar_empty, 1);
    cyc(0, 0, 0, 0, 0);
    chk("t1_pulse", if0.m_axis_pop_valid, 0);

    // 2: equal ranks leave in arrival order
    cyc(0, 1, 5, 7, 0);
    cyc(0, 1, 5, 8, 0);
    pop0("t2_pop0", 7);
    pop0("t2_pop1", 8);

    // 3: backpressure when full, insert+pop accepted
    cyc(0, 1, 10, 1, 0);
    cyc(0, 1, 20, 2, 0);
    cyc(0, 1, 30, 3, 0);
    cyc(0, 1, 40, 4, 0);
    chk("t3_full", if0.m_axis_calendar_full, 1);
    chk("t3_ready", if0.s_axis_insert_ready, 0);
    if0.s_axis_pop_en = 1'b1;
    #1;
    chk("t3_ready_pop", if0.s_axis_insert_ready, 1);
    cyc(0, 1, 1, 5, 1);
    chk("t3_pv", if0.m_axis_pop_valid, 1);
    chk("t3_pa", if0.m_axis_buffer_addr, 1);
    chk("t3_top", if0.m_axis_top_rank, 1);
    chk("t3_count", if0.m_axis_calendar_count, 4);
    chk("t3_nodrop", if0.m_axis_drop_valid, 0);
    pop0("t3_d0", 5);
    pop0("t3_d1", 2);
    pop0("t3_d2", 3);
    pop0("t3_d3", 4);
    chk("t3_empty", if0.m_axis_calendar_empty, 1);

    // 4: evict-worst on the mode-1 instance
    cyc(1, 1, 10, 1, 0);
    cyc(1, 1, 20, 2, 0);
    cyc(1, 1, 30, 3, 0);
    cyc(1, 1, 40, 4, 0);
    chk("t4_full", if1.m_axis_calendar_full, 1);
    chk("t4_ready", if1.s_axis_insert_ready, 1);
    chk("t4_nodrop", if1.m_axis_drop_valid, 0);
    cyc(1, 1, 25, 9, 0);
    chk("t4_ev_dv", if1.m_axis_drop_valid, 1);
    chk("t4_ev_da", if1.m_axis_drop_addr, 4);
    chk("t4_ev_cnt", if1.m_axis_calendar_count, 4);
    cyc(1, 1, 50, 11, 0);
    chk("t4_rej_dv", if1.m_axis_drop_valid, 1);
    chk("t4_rej_da", if1.m_axis_drop_addr, 11);
    cyc(1, 1, 30, 12, 0);
    chk("t4_tie_dv", if1.m_axis_drop_valid, 1);
    chk("t4_tie_da", if1.m_axis_drop_addr, 12);
    cyc(1, 0, 0, 0, 0);
    chk("t4_pulse", if1.m_axis_drop_valid, 0);
    pop1("t4_p0", 10, 1);
    pop1("t4_p1", 20, 2);
    pop1("t4_p2", 25, 9);
    pop1("t4_p3", 30, 3);
    chk("t4_empty", if1.m_axis_calendar_empty, 1);

    // 5: pop on empty ignored, insert+pop on empty inserts
    cyc(0, 0, 0, 0, 1);
    chk("t5_pv", if0.m_axis_pop_valid, 0);
    chk("t5_cnt", if0.m_axis_calendar_count, 0);
    cyc(0, 1, 3, 6, 1);
    chk("t5_cnt1", if0.m_axis_calendar_count, 1);
    chk("t5_pv1", if0.m_axis_pop_valid, 0);
    chk("t5_top", if0.m_axis_top_rank, 3);
    pop0("t5_pop", 6);

    // 6: async reset with a pop pulse live
    cyc(0, 1, 30, 1, 0);
    cyc(0, 1, 10, 2, 0);
    cyc(0, 1, 20, 3, 0);
    cyc(0, 0, 0, 0, 1);
    chk("t6_inflight", if0.m_axis_pop_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6_pv", if0.m_axis_pop_valid, 0);
    chk("t6_cnt", if0.m_axis_calendar_count, 0);
    chk("t6_empty", if0.m_axis_calendar_empty, 1);
    chk("t6_ready", if0.s_axis_insert_ready, 0);
    #2 rst = 1'b0;
    cyc(0, 1, 30, 1, 0);
    cyc(0, 1, 10, 2, 0);
    cyc(0, 1, 20, 3, 0);
    chk("t6_count", if0.m_axis_calendar_count, 3);
    chk("t6_top", if0.m_axis_top_rank, 10);
    pop0("t6_pop0", 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
